// File: rtl/uart_ctrl_pkg.sv
// Shared UART control definitions: FSM state encoding, default byte width, grant-index width.
// Also imported by the command/ALU controller; no logic lives here.
package uart_ctrl_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } uart_state_t;

  // Width of an index into n requesters; at least one bit so a 1-wide port stays legal.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set bit of valid, searching last+1, last+2, ... modulo N_REQ.
// Latency: combinational. Backpressure: none; the caller decides when a pick is used.
// Outputs a one-hot grant, its index, and a flag that something was found.
module rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]          valid,
  input  logic [grant_w(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]          gnt,
  output logic [grant_w(N_REQ)-1:0] idx,
  output logic                      any
);

  localparam int GW = grant_w(N_REQ);

  logic [GW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // Offsets run 1..N_REQ so the previous owner is considered last.
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(last) + i) % N_REQ);
      if (!any && valid[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte sources; optional WAIT watchdog via UART_ARB_TIMEOUT_EN.
// Latency: accept in cycle k -> tx_start in k+1; tx_done in cycle m -> done_pulse and new acceptance possible in m+1.
// Backpressure: req_ready is offered only in IDLE; the transmitter is held until its tx_done (or watchdog expiry).
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [grant_w(N_REQ)-1:0] grant_id,
  output logic [N_REQ-1:0]          done_pulse,
  output logic                      timeout_err
);

  localparam int GW = grant_w(N_REQ);

  uart_state_t       state;
  logic [GW-1:0]     last;
  logic [N_REQ-1:0]  pick_gnt;
  logic [GW-1:0]     pick_idx;
  logic              pick_any;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid (req_valid),
    .last  (last),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // No tx_done term here: acceptance only depends on state and the requests.
  assign req_ready = (state == ST_IDLE) ? pick_gnt : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last       <= GW'(N_REQ - 1);
      tx_start   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      done_pulse <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      tx_start   <= 1'b0;
      done_pulse <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            tx_data  <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
            grant_id <= pick_idx;
            last     <= pick_idx;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          // A frame that ends on the expiry cycle still counts as delivered.
          if (tx_done) begin
            state                <= ST_IDLE;
            busy                 <= 1'b0;
            done_pulse[grant_id] <= 1'b1;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares the single UART transmitter among `N_REQ` requesters, such as the ALU result path and a status/echo source. It accepts one byte per grant through a valid/ready handshake, then issues a one-cycle start pulse to the transmitter. It holds the transmitter until the transmitter's end-of-frame pulse arrives, then arbitrates the next byte. It sits between the command/ALU control logic and the UART transmitter.

## Interface
Parameters:
- `DATA_W`, 8, byte width sent to the transmitter.
- `N_REQ`, 2, number of requesters; legal range is 2 to 8.
- `TIMEOUT_CYC`, 4096, cycles allowed in WAIT; used only with `UART_ARB_TIMEOUT_EN`; minimum 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester byte available; held with data until accepted.
- `req_data`  in  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ  one-hot, one cycle, combinational in IDLE; marks acceptance.
- `tx_start`  out  1  registered one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W  registered latched byte; stable from START until leaving WAIT.
- `tx_done`  in  1  one-cycle end-of-frame pulse from the transmitter.
- `busy`  out  1  high in START and WAIT.
- `grant_id`  out  max(1,$clog2(N_REQ))  index of the current or last owner.
- `done_pulse`  out  N_REQ  one-cycle, one-hot; the owner's byte has finished transmitting.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE, START, WAIT. The reset state is IDLE.
- In IDLE, the block selects the first requester with `req_valid` set, searching `last+1, last+2, …` modulo `N_REQ`.
- On selection:
  - `req_ready[g]` is high that same cycle.
  - On the clock edge, `tx_data` takes `req_data[g]`, `grant_id` takes g, `last` takes g, and the FSM moves to START.
- START:
  - `tx_start` is 1 for exactly this cycle.
  - The FSM moves to WAIT unconditionally.
- WAIT:
  - If `tx_done` is 1, the FSM moves to IDLE and `done_pulse[grant_id]` is 1 in the next cycle.
  - Otherwise the FSM stays in WAIT.
- `tx_done` is ignored in IDLE and START.
- A requester that drops `req_valid` before acceptance is simply not served. No state is kept per requester.
- Round-robin fairness: with all requesters valid, grants cycle 0, 1, …, N_REQ-1, 0, …
- The `last` pointer resets to N_REQ-1, so requester 0 wins the first arbitration.
- Reset values of all outputs are 0: `req_ready`, `tx_start`, `tx_data`, `busy`, `grant_id`, `done_pulse`, `timeout_err`.
- Reset during START or WAIT returns the FSM to IDLE in the next cycle. The block does not abort the transmitter; the transmitter's own reset does that.

## Timing
- Request accepted in cycle k gives `tx_start` in cycle k+1 and WAIT from cycle k+2.
- `tx_done` in cycle m gives IDLE and `done_pulse` in cycle m+1. A new acceptance can occur in cycle m+1.
- Minimum overhead is 3 cycles per byte beyond the transmitter frame time.
- `req_ready` depends combinationally on `req_valid` and the FSM state only. There is no path from `tx_done` to `req_ready`.
- `done_pulse` and `timeout_err` never assert in the same cycle.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A cycle counter of width $clog2(TIMEOUT_CYC)+1 clears when the FSM enters WAIT and increments on every WAIT cycle.
  - When the counter reaches TIMEOUT_CYC-1 and `tx_done` is 0, the FSM returns to IDLE and `timeout_err` pulses in the next cycle. No `done_pulse` is issued.
  - If `tx_done` and expiry happen in the same cycle, `tx_done` wins.
- Without the macro:
  - The counter is not synthesized.
  - `timeout_err` is tied to 0.
  - WAIT lasts until `tx_done`, with no limit.

## Structure
- Shared package file `uart_ctrl_pkg` holds:
  - the state encoding constants ST_IDLE, ST_START, ST_WAIT;
  - the default DATA_W;
  - the grant-index width function.
  The command/ALU controller reuses the same package.
- Sub-module `rr_pick`: combinational block taking the `req_valid` vector and the `last` pointer. It outputs a one-hot grant, a grant index and an `any` flag. It is instantiated once.

## Test plan
- Reset, then req_valid=01 with req_data[0]=0x5A:
  - `req_ready`=01 in the same cycle.
  - `tx_start` one cycle later with `tx_data`=0x5A.
  - `tx_done` 10 cycles later gives `done_pulse`=01 on the next cycle.
- Both requesters valid continuously (0x11 and 0x22), 4 frames: grant order is 0, 1, 0, 1 and the `tx_data` sequence is 0x11, 0x22, 0x11, 0x22.
- `tx_done` pulsed during IDLE and during START: no state change, no `done_pulse`, and the frame still waits for a later `tx_done`.
- Reset asserted 3 cycles into WAIT: next cycle all outputs are 0 and the FSM is in IDLE; the next grant goes to requester 0 even if requester 1 also requests.
- With `UART_ARB_TIMEOUT_EN`, TIMEOUT_CYC=8, `tx_done` never sent:
  - `timeout_err` pulses 8 cycles after WAIT is entered, and `busy` then drops.
  - A repeat with `tx_done` sent on the expiry cycle gives `done_pulse` instead of `timeout_err`.
- N_REQ=4 with only requesters 1 and 3 valid, after last=1: the grant goes to 3, then 1.
